// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-game datapath: colour type, playback
// FSM states, LED one-hot decode and the LFSR tap set.
package game_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ON,
    ST_OFF,
    ST_FIN
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam int LFSR_TAP0 = 15;
  localparam int LFSR_TAP1 = 13;
  localparam int LFSR_TAP2 = 12;
  localparam int LFSR_TAP3 = 10;

  function automatic logic [3:0] color_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shared by the pattern generator and
// the random-delay logic.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb_d;

  assign fb_d = q_q[LFSR_TAP0] ^ q_q[LFSR_TAP1] ^ q_q[LFSR_TAP2] ^ q_q[LFSR_TAP3];

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= {q_q[14:0], fb_d};
  end

  assign q = q_q;

endmodule

// File: rtl/sequence_player.sv
// Memory-game pattern store and playback controller: grows a random colour
// sequence and plays it on four LEDs paced by the external tick counter.
module sequence_player
  import game_pkg::*;
#(
  parameter int          MAX_LEN = 16,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         grow,
  input  logic                         clear,
  output logic                         timer_en,
  output logic                         timer_rst,
  output logic [3:0]                   led,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [1:0]                   rd_color
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  logic [15:0]   lfsr;
  logic          unused_lfsr_hi;
  color_t        pattern_q [MAX_LEN];
  state_t        state_q;
  logic [LW-1:0] len_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [3:0]    led_q;
  logic          timer_en_q;
  logic          timer_rst_q;
  logic          done_q;
  logic          full;
  logic          last;
  logic          grow_ok;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:2];

  assign full    = (len_q == LW'(MAX_LEN));
  assign idx_d   = idx_q + IW'(1);
  assign last    = ((LW'(idx_q) + LW'(1)) == len_q);
  // Matches the IDLE priority below: clear beats grow, and a full store drops grow.
  assign grow_ok = !reset && (state_q == ST_IDLE) && !clear && grow && !full;

  always_ff @(posedge clk) begin
    if (grow_ok) pattern_q[len_q[IW-1:0]] <= lfsr[1:0];
  end

  // Outputs are registered from the transition taken, so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      led_q       <= '0;
      timer_en_q  <= 1'b0;
      timer_rst_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      timer_rst_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            len_q <= '0;
          end else if (grow) begin
            if (!full) len_q <= len_q + LW'(1);
          end else if (start) begin
            if (len_q == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= ST_SYNC;
              timer_rst_q <= 1'b1;
            end
          end
        end
        ST_SYNC: begin
          idx_q      <= '0;
          led_q      <= color_onehot(pattern_q[0]);
          timer_en_q <= 1'b1;
          state_q    <= ST_ON;
        end
        ST_ON: begin
          if (tick) begin
            led_q   <= '0;
            state_q <= ST_OFF;
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (last) begin
              timer_en_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_FIN;
            end else begin
              idx_q   <= idx_d;
              led_q   <= color_onehot(pattern_q[idx_d]);
              state_q <= ST_ON;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign timer_en  = timer_en_q;
  assign timer_rst = timer_rst_q;
  assign led       = led_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign len       = len_q;
  assign rd_color  = pattern_q[rd_idx];

endmodule

// File: tb/tb_sequence_player.sv
// Randomised scenario bench for sequence_player against a pattern/length model.
module tb_sequence_player;

  localparam int          MAX_LEN = 16;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          TP      = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, start = 1'b0, grow = 1'b0, clear = 1'b0;
  logic       timer_en, timer_rst, busy, done;
  logic [3:0] led;
  logic [4:0] len;
  logic [3:0] rd_idx = 4'd0;
  logic [1:0] rd_color;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr = SEED;
  logic [1:0]  m_pat [MAX_LEN];
  int          m_len = 0;

  sequence_player #(.MAX_LEN(MAX_LEN), .SEED(SEED)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .grow     (grow),
    .clear    (clear),
    .timer_en (timer_en),
    .timer_rst(timer_rst),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .len      (len),
    .rd_idx   (rd_idx),
    .rd_color (rd_color)
  );

  always #5 clk = ~clk;

  // Reference LFSR: same polynomial, reseeded by reset, steps every clock.
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [3:0] exp_led(input logic [1:0] c);
    case (c)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // One IDLE command for one cycle; model applies clear > grow priority.
  task automatic do_cmd(input logic c, input logic g, input logic s);
    clear = c; grow = g; start = s;
    if (c) m_len = 0;
    else if (g && m_len < MAX_LEN) begin
      m_pat[m_len] = m_lfsr[1:0];
      m_len++;
    end
    @(negedge clk);
    clear = 1'b0; grow = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (len !== 5'd0) begin errors++; $display("FAIL reset_len got %0d want 0", len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL reset_led got %b want 0000", led); end
    checks++; if ({timer_en, timer_rst, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {timer_en, timer_rst, done}); end
    reset = 1'b0;
    m_len = 0;
    @(negedge clk);
  endtask

  task automatic test_grow();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_cmd(1'b0, 1'b1, 1'b0);
    end
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL grow_len got %0d want 3", len); end
    for (int i = 0; i < 3; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_color !== m_pat[i]) begin errors++; $display("FAIL grow_color[%0d] got %0d want %0d", i, rd_color, m_pat[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_playback();
    logic [3:0] prev;
    logic [3:0] lit [MAX_LEN];
    int nruns, runlen, done_at, done_cnt, rst_cnt, en_gap, exp_done;
    prev = 4'd0; nruns = 0; runlen = 0; done_at = -1; done_cnt = 0; rst_cnt = 0; en_gap = 0;
    exp_done = 2 * m_len * TP + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (timer_rst !== 1'b1) begin errors++; $display("FAIL play_timer_rst got %b want 1", timer_rst); end
    for (int phase = 0; phase <= 2 * MAX_LEN * TP + 20; phase++) begin
      if (timer_rst) rst_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = phase; end
      if (phase >= 1 && phase < exp_done && !timer_en) en_gap++;
      if (led != 4'd0) begin
        if (prev == 4'd0) begin
          if (nruns < MAX_LEN) lit[nruns] = led;
          nruns++; runlen = 1;
        end else runlen++;
      end else if (prev != 4'd0) begin
        checks++; if (runlen !== TP) begin errors++; $display("FAIL play_lit_width got %0d want %0d", runlen, TP); end
      end
      prev = led;
      tick = (phase > 0 && phase % TP == 0 && busy);
      @(negedge clk);
      tick = 1'b0;
      if (done_at >= 0) break;
    end
    checks++; if (done_at !== exp_done) begin errors++; $display("FAIL play_done_time got %0d want %0d", done_at, exp_done); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL play_after_done busy/done got %b want 00", {busy, done}); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL play_done_count got %0d want 1", done_cnt); end
    checks++; if (rst_cnt !== 1) begin errors++; $display("FAIL play_rst_count got %0d want 1", rst_cnt); end
    checks++; if (en_gap !== 0) begin errors++; $display("FAIL play_timer_en gaps got %0d want 0", en_gap); end
    checks++; if (nruns !== m_len) begin errors++; $display("FAIL play_runs got %0d want %0d", nruns, m_len); end
    for (int i = 0; i < m_len && i < nruns; i++) begin
      checks++; if (lit[i] !== exp_led(m_pat[i])) begin errors++; $display("FAIL play_led[%0d] got %b want %b", i, lit[i], exp_led(m_pat[i])); end
    end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    do_cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) do_cmd(1'b0, 1'b1, 1'b0);
    checks++; if (len !== 5'd16) begin errors++; $display("FAIL sat_len16 got %0d want 16", len); end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    do_cmd(1'b0, 1'b1, 1'b0);
    checks++; if (len !== 5'd16) begin errors++; $display("FAIL sat_len17 got %0d want 16", len); end
    for (int i = 0; i < MAX_LEN; i++) begin
      rd_idx = 4'(i); #1;
      checks++; if (rd_color !== m_pat[i]) begin errors++; $display("FAIL sat_color[%0d] got %0d want %0d", i, rd_color, m_pat[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    do_cmd(1'b1, 1'b0, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b0);
    do_cmd(1'b1, 1'b1, 1'b1);
    checks++; if (len !== 5'd0) begin errors++; $display("FAIL cgs_len got %0d want 0", len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cgs_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if ({busy, done, timer_rst} !== 3'b000) begin errors++; $display("FAIL cgs_quiet got %b want 000", {busy, done, timer_rst}); end
    do_cmd(1'b0, 1'b1, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b1);
    checks++; if (len !== 5'd3) begin errors++; $display("FAIL gs_len got %0d want 3", len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gs_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if ({busy, timer_rst, done} !== 3'b000) begin errors++; $display("FAIL gs_quiet got %b want 000", {busy, timer_rst, done}); end
    rd_idx = 4'd2; #1;
    checks++; if (rd_color !== m_pat[2]) begin errors++; $display("FAIL gs_color2 got %0d want %0d", rd_color, m_pat[2]); end
    @(negedge clk);
  endtask

  task automatic test_start_empty();
    do_cmd(1'b1, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done got %b want 1", done); end
    checks++; if ({timer_rst, timer_en, led, busy} !== 7'd0) begin errors++; $display("FAIL empty_quiet got %b want 0000000", {timer_rst, timer_en, led, busy}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_width got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] prev;
    int nruns, activity;
    bit hit;
    prev = 4'd0; nruns = 0; activity = 0; hit = 1'b0;
    for (int i = 0; i < 3; i++) do_cmd(1'b0, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int phase = 0; phase <= 4 * TP + 10; phase++) begin
      if (led != 4'd0 && prev == 4'd0) nruns++;
      prev = led;
      if (nruns == 2) begin hit = 1'b1; break; end
      tick = (phase > 0 && phase % TP == 0 && busy);
      @(negedge clk);
      tick = 1'b0;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rmid_reach_2nd got %b want 1", hit); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_len = 0;
    checks++; if ({led, busy, done, timer_en} !== 7'd0) begin errors++; $display("FAIL rmid_outputs got %b want 0000000", {led, busy, done, timer_en}); end
    checks++; if (len !== 5'd0) begin errors++; $display("FAIL rmid_len got %0d want 0", len); end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 2 * TP; i++) begin
      if (busy || done || timer_en || timer_rst || led != 4'd0) activity++;
      @(negedge clk);
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL rmid_activity got %0d want 0", activity); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_grow();
    test_playback();
    test_saturate();
    test_same_cycle();
    test_playback();
    test_start_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
Memory-game pattern store and playback controller. It consumes the one-cycle timer tick from the 25-bit tick counter, drives that counter's en/reset, and uses the ticks to show a stored colour sequence on four LEDs. Each grow request appends one LFSR-random colour. The stored sequence is exposed on a read port for the downstream player-input checker.

Parameters:
MAX_LEN, 16, maximum sequence length (power of 2, 2..64)
SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse from tick counter timerout
start  in  1  pulse: play back stored sequence
grow  in  1  pulse: append one random colour
clear  in  1  pulse: empty the sequence
timer_en  out  1  enable to tick counter
timer_rst  out  1  reset to tick counter, one-cycle pulse
led  out  4  one-hot colour display, 0 = dark
busy  out  1  high while not in IDLE
done  out  1  one-cycle pulse at end of playback
len  out  $clog2(MAX_LEN+1)  current sequence length
rd_idx  in  $clog2(MAX_LEN)  checker read index
rd_color  out  2  pattern[rd_idx], combinational

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE, len=0, idx=0, lfsr=SEED. led, timer_en, timer_rst and done all 0. Reset mid-playback aborts immediately with no done pulse.
- LFSR: 16-bit Fibonacci register, steps every clk including IDLE.
  - fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}.
  - Sampled colour = lfsr[1:0].
- Pattern storage: MAX_LEN x 2-bit register array. Not cleared by reset; only entries below len are meaningful.
- IDLE command priority, one command accepted per cycle: clear > grow > start.
  - clear: len <= 0.
  - grow: if len < MAX_LEN then pattern[len] <= lfsr[1:0] and len <= len+1. If full, ignored with no wrap.
  - start, len == 0: done pulses the next cycle; state stays IDLE.
  - start, len > 0: go to SYNC.
- Commands outside IDLE are ignored.
- FSM states: IDLE, SYNC, ON, OFF, FIN.
  - SYNC: idx <= 0. timer_rst=1 for this one cycle, which restarts the counter phase. Next state is ON.
  - ON: led = onehot(pattern[idx]), where 0->0001, 1->0010, 2->0100, 3->1000. timer_en=1. On tick, go to OFF.
  - OFF: led = 0000, timer_en=1. On tick: if idx == len-1 go to FIN, else idx <= idx+1 and go to ON.
  - FIN: done=1 for one cycle, timer_en=0. Next state is IDLE.
- tick is ignored in IDLE, SYNC and FIN.
- Cycle timing:
  - led becomes valid the cycle after entering ON and goes dark the cycle after the tick.
  - Each colour is lit for exactly one tick period and dark for one.
  - Total playback takes 2*len ticks.
- busy = (state != IDLE).
- rd_color is combinational and valid in any state. An rd_idx >= len returns a stale value, which the checker must not use.
- All outputs are registered except rd_color, busy and len (direct state decodes).

Decomposition:
- Shared package game_pkg:
  - colour typedef (2-bit).
  - FSM state enum.
  - onehot colour-to-LED function.
  - LFSR tap constants and default SEED.
- One sub-module, lfsr16 (parameter SEED; ports clk, reset, q[15:0]). It is reused later by the game's random-delay logic.
- Pattern array and FSM stay inline.

Test Plan:
- Reset, then grow x3 at known cycles -> len=3. rd_color for idx 0..2 matches a bench LFSR model seeded 16'hACE1 at those cycles.
- len=3 with pattern forced via grows, start, tick every 8 cycles:
  - timer_rst pulses once, one cycle after start.
  - led shows 3 lit/dark pairs matching rd_color, with 6 ticks total.
  - done pulses once, then busy=0.
- grow x17 with MAX_LEN=16 -> len saturates at 16, and pattern[0..15] is unchanged by the 17th grow.
- Same-cycle commands in IDLE:
  - clear+grow+start -> only clear takes effect: len=0, no playback.
  - grow+start with len=2 -> len=3, still IDLE, busy=0.
- start with len=0 -> done=1 exactly one cycle later, and timer_rst, timer_en and led all stay 0.
- Reset asserted during ON of the 2nd colour -> next cycle: led=0, busy=0, len=0, and no done pulse; a following tick causes no activity.
